// File: rtl/vscale_md_requester.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vscale_md_requester
//   Decodes RV32M instructions into mul/div unit requests, resolves the
//   divide-by-zero and signed-overflow cases locally, holds the result for
//   writeback.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module vscale_md_requester #(
  parameter int XPR_LEN = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [2:0]         issue_funct3,
  input  logic [XPR_LEN-1:0] issue_rs1,
  input  logic [XPR_LEN-1:0] issue_rs2,
  input  logic               kill,
  output logic               req_valid,
  input  logic               req_ready,
  output logic               req_in_1_signed,
  output logic               req_in_2_signed,
  output logic [1:0]         req_op,
  output logic [1:0]         req_out_sel,
  output logic [XPR_LEN-1:0] req_in_1,
  output logic [XPR_LEN-1:0] req_in_2,
  input  logic               resp_valid,
  input  logic [XPR_LEN-1:0] resp_result,
  output logic               wb_valid,
  output logic [XPR_LEN-1:0] wb_data,
  input  logic               wb_ack
);

  localparam logic [1:0] c_op_mul  = 2'd0;
  localparam logic [1:0] c_op_div  = 2'd1;
  localparam logic [1:0] c_op_rem  = 2'd2;
  localparam logic [1:0] c_sel_lo  = 2'd0;
  localparam logic [1:0] c_sel_hi  = 2'd1;
  localparam logic [1:0] c_sel_rem = 2'd2;
  localparam logic [XPR_LEN-1:0] c_int_min = {1'b1, {(XPR_LEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic               r_req_valid;
  logic               r_s1;
  logic               r_s2;
  logic [1:0]         r_op;
  logic [1:0]         r_sel;
  logic [XPR_LEN-1:0] r_in_1;
  logic [XPR_LEN-1:0] r_in_2;
  logic               r_wb_valid;
  logic [XPR_LEN-1:0] r_wb_data;

  logic               w_s1;
  logic               w_s2;
  logic [1:0]         w_op;
  logic [1:0]         w_sel;
  logic               w_is_div;
  logic               w_is_rem;
  logic               w_div_zero;
  logic               w_ovf;
  logic               w_special;
  logic [XPR_LEN-1:0] w_special_result;

  always_comb begin
    w_op  = c_op_mul;
    w_sel = c_sel_lo;
    w_s1  = 1'b1;
    w_s2  = 1'b1;
    case (issue_funct3)
      3'b000: ;
      3'b001: w_sel = c_sel_hi;
      3'b010: begin w_sel = c_sel_hi; w_s2 = 1'b0; end
      3'b011: begin w_sel = c_sel_hi; w_s1 = 1'b0; w_s2 = 1'b0; end
      3'b100: w_op = c_op_div;
      3'b101: begin w_op = c_op_div; w_s1 = 1'b0; w_s2 = 1'b0; end
      3'b110: begin w_op = c_op_rem; w_sel = c_sel_rem; end
      default: begin w_op = c_op_rem; w_sel = c_sel_rem; w_s1 = 1'b0; w_s2 = 1'b0; end
    endcase
  end

  assign w_is_div   = (issue_funct3[2:1] == 2'b10);
  assign w_is_rem   = (issue_funct3[2:1] == 2'b11);
  assign w_div_zero = (issue_rs2 == '0);
  // Overflow only exists for the signed forms (funct3[0] clear).
  assign w_ovf      = !issue_funct3[0] && (issue_rs1 == c_int_min) && (issue_rs2 == '1);

  always_comb begin
    w_special        = 1'b0;
    w_special_result = '0;
    if (w_is_div || w_is_rem) begin
      if (w_div_zero) begin
        w_special        = 1'b1;
        w_special_result = w_is_div ? '1 : issue_rs1;
      end else if (w_ovf) begin
        w_special        = 1'b1;
        w_special_result = w_is_div ? c_int_min : '0;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (issue_valid && !kill) w_next = w_special ? S_DONE : S_REQ;
      S_REQ: begin
        if (kill)           w_next = req_ready ? S_DRAIN : S_IDLE;
        else if (req_ready) w_next = S_WAIT;
      end
      S_WAIT: begin
        // A response coinciding with the kill completes the unit's work, so no drain is needed.
        if (kill)            w_next = resp_valid ? S_IDLE : S_DRAIN;
        else if (resp_valid) w_next = S_DONE;
      end
      S_DRAIN: if (resp_valid) w_next = S_IDLE;
      S_DONE:  if (wb_ack || kill) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_req_valid <= 1'b0;
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_op        <= 2'd0;
      r_sel       <= 2'd0;
      r_in_1      <= '0;
      r_in_2      <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_data   <= '0;
    end else begin
      r_state     <= w_next;
      r_req_valid <= (w_next == S_REQ);
      r_wb_valid  <= (w_next == S_DONE);
      if (r_state == S_IDLE && w_next == S_REQ) begin
        r_s1   <= w_s1;
        r_s2   <= w_s2;
        r_op   <= w_op;
        r_sel  <= w_sel;
        r_in_1 <= issue_rs1;
        r_in_2 <= issue_rs2;
      end
      if (r_state == S_IDLE && w_next == S_DONE) r_wb_data <= w_special_result;
      if (r_state == S_WAIT && w_next == S_DONE) r_wb_data <= resp_result;
    end
  end

  assign issue_ready     = (r_state == S_IDLE);
  assign req_valid       = r_req_valid;
  assign req_in_1_signed = r_s1;
  assign req_in_2_signed = r_s2;
  assign req_op          = r_op;
  assign req_out_sel     = r_sel;
  assign req_in_1        = r_in_1;
  assign req_in_2        = r_in_2;
  assign wb_valid        = r_wb_valid;
  assign wb_data         = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_vscale_md_requester.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vscale_md_requester
//   Directed vector table plus hand-written kill/reset sequences.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_vscale_md_requester;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [2:0]  issue_funct3 = 3'd0;
  logic [31:0] issue_rs1 = '0;
  logic [31:0] issue_rs2 = '0;
  logic        kill = 1'b0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic        req_in_1_signed;
  logic        req_in_2_signed;
  logic [1:0]  req_op;
  logic [1:0]  req_out_sel;
  logic [31:0] req_in_1;
  logic [31:0] req_in_2;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_result = '0;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        wb_ack = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vscale_md_requester #(.XPR_LEN(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_funct3(issue_funct3), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .kill(kill),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in_1_signed(req_in_1_signed), .req_in_2_signed(req_in_2_signed),
    .req_op(req_op), .req_out_sel(req_out_sel),
    .req_in_1(req_in_1), .req_in_2(req_in_2),
    .resp_valid(resp_valid), .resp_result(resp_result),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_ack(wb_ack)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        special;
    logic [1:0]  op;
    logic [1:0]  sel;
    logic        s1;
    logic        s2;
    logic [31:0] result;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  function automatic logic [5:0] fields();
    return {req_op, req_out_sel, req_in_1_signed, req_in_2_signed};
  endfunction

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    issue_funct3 = f3;
    issue_rs1    = a;
    issue_rs2    = b;
    issue_valid  = 1'b1;
    tick();
    issue_valid  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    issue(v.f3, v.rs1, v.rs2);
    if (v.special) begin
      check({tag, "_sp_reqv"}, {63'd0, req_valid}, 64'd0);
      check({tag, "_sp_wbv"},  {63'd0, wb_valid}, 64'd1);
      check({tag, "_sp_data"}, {32'd0, wb_data}, {32'd0, v.result});
      check({tag, "_sp_rdy"},  {63'd0, issue_ready}, 64'd0);
    end else begin
      check({tag, "_reqv"},   {63'd0, req_valid}, 64'd1);
      check({tag, "_fields"}, {58'd0, fields()}, {58'd0, v.op, v.sel, v.s1, v.s2});
      check({tag, "_ops"},    {req_in_1, req_in_2}, {v.rs1, v.rs2});
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      check({tag, "_reqv_drop"}, {63'd0, req_valid}, 64'd0);
      ticks(33);
      check({tag, "_wbv_early"}, {63'd0, wb_valid}, 64'd0);
      resp_valid  = 1'b1;
      resp_result = v.result;
      tick();
      resp_valid  = 1'b0;
      resp_result = 32'hDEAD_BEEF;
      check({tag, "_wbv"},  {63'd0, wb_valid}, 64'd1);
      check({tag, "_data"}, {32'd0, wb_data}, {32'd0, v.result});
    end
    tick();
    check({tag, "_hold"}, {31'd0, wb_valid, wb_data}, {31'd0, 1'b1, v.result});
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    check({tag, "_ack"}, {62'd0, wb_valid, issue_ready}, {62'd0, 2'b01});
  endtask

  initial begin
    vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 32'hFFFF_FFEB};
    vecs[1]  = '{3'b001, 32'h0001_0000,  32'h0001_0000, 1'b0, 2'd0, 2'd1, 1'b1, 1'b1, 32'h0000_0001};
    vecs[2]  = '{3'b010, 32'hFFFF_FFFF,  32'd2,         1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 32'hFFFF_FFFF};
    vecs[3]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 32'hFFFF_FFFE};
    vecs[4]  = '{3'b100, 32'd100,        32'd7,         1'b0, 2'd1, 2'd0, 1'b1, 1'b1, 32'd14};
    vecs[5]  = '{3'b101, 32'hFFFF_FFFE,  32'd2,         1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 32'h7FFF_FFFF};
    vecs[6]  = '{3'b110, 32'hFFFF_FFF9,  32'd3,         1'b0, 2'd2, 2'd2, 1'b1, 1'b1, 32'hFFFF_FFFF};
    vecs[7]  = '{3'b111, 32'd17,         32'd5,         1'b0, 2'd2, 2'd2, 1'b0, 1'b0, 32'd2};
    vecs[8]  = '{3'b100, 32'd100,        32'd0,         1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 32'hFFFF_FFFF};
    vecs[9]  = '{3'b101, 32'd5,          32'd0,         1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 32'hFFFF_FFFF};
    vecs[10] = '{3'b111, 32'd100,        32'd0,         1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 32'd100};
    vecs[11] = '{3'b110, 32'h0000_1234,  32'd0,         1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 32'h0000_1234};
    vecs[12] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 32'h8000_0000};
    vecs[13] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 32'd0};
    vecs[14] = '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 32'd0};

    #12;
    check("rst_outs", {30'd0, req_valid, wb_valid, wb_data}, 64'd0);
    check("rst_req", {req_in_1, req_in_2}, 64'd0);
    check("rst_fields", {58'd0, fields()}, 64'd0);
    reset_n = 1'b1;
    tick();
    check("rst_ready", {63'd0, issue_ready}, 64'd1);

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // kill beats issue_valid in IDLE
    issue_valid = 1'b1; kill = 1'b1;
    tick();
    issue_valid = 1'b0; kill = 1'b0;
    check("kill_idle", {62'd0, issue_ready, req_valid}, {62'd0, 2'b10});

    // REQ stall with stable fields, then kill while not ready
    issue(3'b010, 32'hCAFE_0001, 32'h0000_0042);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d", i), {57'd0, req_valid, fields()}, {57'd0, 1'b1, 2'd0, 2'd1, 1'b1, 1'b0});
      check($sformatf("stall_ops%0d", i), {req_in_1, req_in_2}, {32'hCAFE_0001, 32'h0000_0042});
      tick();
    end
    check("stall_busy", {63'd0, issue_ready}, 64'd0);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill_req_nordy", {62'd0, issue_ready, req_valid}, {62'd0, 2'b10});
    ticks(3);
    check("kill_req_nowb", {63'd0, wb_valid}, 64'd0);

    // kill in REQ with handshake -> DRAIN, issue ignored while draining
    issue(3'b000, 32'd3, 32'd4);
    req_ready = 1'b1; kill = 1'b1;
    tick();
    req_ready = 1'b0; kill = 1'b0;
    check("kill_req_rdy", {62'd0, issue_ready, req_valid}, 64'd0);
    issue(3'b000, 32'd9, 32'd9);
    check("drain_ignore", {62'd0, issue_ready, req_valid}, 64'd0);
    resp_valid = 1'b1; resp_result = 32'd12;
    tick();
    resp_valid = 1'b0;
    check("drain_done", {62'd0, issue_ready, wb_valid}, {62'd0, 2'b10});

    // kill in WAIT at issue+10 -> DRAIN
    issue(3'b000, 32'd6, 32'd7);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    ticks(8);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill_wait", {62'd0, issue_ready, wb_valid}, 64'd0);
    ticks(5);
    check("kill_wait_hold", {62'd0, issue_ready, wb_valid}, 64'd0);
    resp_valid = 1'b1; resp_result = 32'd42;
    tick();
    resp_valid = 1'b0;
    check("kill_wait_drained", {62'd0, issue_ready, wb_valid}, {62'd0, 2'b10});
    run_vec(vecs[7], 99);

    // kill coinciding with resp in WAIT -> straight to IDLE
    issue(3'b000, 32'd2, 32'd2);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    ticks(2);
    kill = 1'b1; resp_valid = 1'b1; resp_result = 32'd4;
    tick();
    kill = 1'b0; resp_valid = 1'b0;
    check("kill_resp_wait", {62'd0, issue_ready, wb_valid}, {62'd0, 2'b10});

    // kill in DONE
    issue(3'b101, 32'd1, 32'd0);
    check("done_pre", {63'd0, wb_valid}, 64'd1);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill_done", {62'd0, issue_ready, wb_valid}, {62'd0, 2'b10});

    // asynchronous reset during WAIT
    issue(3'b011, 32'h1234_5678, 32'h9ABC_DEF0);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    ticks(4);
    #2 reset_n = 1'b0;
    #1;
    check("arst_outs", {30'd0, req_valid, wb_valid, wb_data}, 64'd0);
    check("arst_req", {req_in_1, req_in_2}, 64'd0);
    check("arst_fields", {58'd0, fields()}, 64'd0);
    check("arst_ready", {63'd0, issue_ready}, 64'd1);
    #2 reset_n = 1'b1;
    tick();
    resp_valid = 1'b1; resp_result = 32'h5555_AAAA;
    tick();
    resp_valid = 1'b0;
    ticks(2);
    check("stray_resp", {31'd0, wb_valid, wb_data}, 64'd0);
    check("stray_ready", {63'd0, issue_ready}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
